// File: rtl/servo_pkg.sv
// Shared types and angle constants for the pick/place servo sequencer.
package servo_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BASE,
    S_ARM,
    S_GRIP,
    S_HOME,
    S_DONE
  } state_e;

  localparam int ANG_W = 8;

  localparam logic [1:0] LEFT  = 2'b01;
  localparam logic [1:0] RIGHT = 2'b10;

  localparam logic [ANG_W-1:0] HOME_ANG   = 8'd90;
  localparam logic [ANG_W-1:0] GRIP_OPEN  = 8'd45;
  localparam logic [ANG_W-1:0] GRIP_CLOSE = 8'd135;
  localparam logic [ANG_W-1:0] BASE_L     = 8'd45;
  localparam logic [ANG_W-1:0] BASE_R     = 8'd135;
  localparam logic [ANG_W-1:0] ANG_MAX    = 8'd180;

endpackage

// File: rtl/servo_ramp_ch.sv
// One servo channel: target register, per-frame slew limiter and PWM compare.
module servo_ramp_ch
  import servo_pkg::*;
#(
  parameter int               FCW         = 20,
  parameter int               MIN_CYC     = 50000,
  parameter int               CYC_PER_DEG = 277,
  parameter int               STEP_DEG    = 5,
  parameter logic [ANG_W-1:0] HOME        = HOME_ANG
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [FCW-1:0]   frame_cnt,
  input  logic             frame_wrap,
  input  logic             tgt_we,
  input  logic [ANG_W-1:0] tgt_in,
  output logic             arrived,
  output logic             pwm
);

  localparam logic [ANG_W-1:0] STEP = ANG_W'(STEP_DEG);

  logic [ANG_W-1:0] cur_q, cur_d, tgt_q, tgt_d;
  logic             pwm_q, pwm_d;

  always_comb begin
    tgt_d = tgt_q;
    if (tgt_we) tgt_d = (tgt_in > ANG_MAX) ? ANG_MAX : tgt_in;

    // cur only moves at the frame boundary so a pulse never changes mid-frame
    cur_d = cur_q;
    if (frame_wrap) begin
      if (tgt_q >= cur_q) cur_d = ((tgt_q - cur_q) <= STEP) ? tgt_q : cur_q + STEP;
      else                cur_d = ((cur_q - tgt_q) <= STEP) ? tgt_q : cur_q - STEP;
    end

    pwm_d = 32'(frame_cnt) < (32'(MIN_CYC) + 32'(cur_q) * 32'(CYC_PER_DEG));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_q <= HOME;
      tgt_q <= HOME;
      pwm_q <= 1'b0;
    end else begin
      cur_q <= cur_d;
      tgt_q <= tgt_d;
      pwm_q <= pwm_d;
    end
  end

  assign arrived = (cur_q == tgt_q);
  assign pwm     = pwm_q;

endmodule

// File: rtl/servo_seq_ctrl.sv
// Multi-channel servo sequencer: shared frame counter, settle counter and
// the base -> arm -> gripper -> home step FSM driving N_CH ramp channels.
module servo_seq_ctrl
  import servo_pkg::*;
#(
  parameter int CLK_HZ        = 50_000_000,
  parameter int PWM_HZ        = 50,
  parameter int N_CH          = 5,
  parameter int MIN_US        = 1000,
  parameter int MAX_US        = 2000,
  parameter int STEP_DEG      = 5,
  parameter int SETTLE_FRAMES = 25,
  parameter int ARM_BASE      = 90,
  parameter int ARM_STEP      = 45,
  localparam int BIN_W        = (N_CH - 2 > 1) ? $clog2(N_CH - 2) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       ir_side,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [N_CH-1:0]  pwm_out
);

  localparam int FRAME_CYC   = CLK_HZ / PWM_HZ;
  localparam int FCW         = $clog2(FRAME_CYC);
  localparam int MIN_CYC     = int'((longint'(MIN_US) * longint'(CLK_HZ)) / 64'd1_000_000);
  localparam int CYC_PER_DEG = (MAX_US - MIN_US) * (CLK_HZ / 1_000_000) / 180;
  localparam int SW          = $clog2(SETTLE_FRAMES + 1);

  state_e           state_q, state_d;
  logic [FCW-1:0]   frame_cnt_q, frame_cnt_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [1:0]       side_q, side_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic             fault_q, fault_d;

  logic                             frame_wrap, all_arrived, step_done;
  logic [N_CH-1:0]                  arrived, tgt_we;
  logic [N_CH-1:0][ANG_W-1:0]       tgt_val;
  logic [31:0]                      arm_sum;
  logic [ANG_W-1:0]                 arm_a;

  assign frame_wrap  = (frame_cnt_q == FCW'(FRAME_CYC - 1));
  assign frame_cnt_d = frame_wrap ? '0 : frame_cnt_q + FCW'(1);
  assign all_arrived = &arrived;
  // exit on the SETTLE_FRAMES-th wrap seen with every channel at target
  assign step_done   = frame_wrap && all_arrived && (settle_q == SW'(SETTLE_FRAMES - 1));

  assign arm_sum = 32'(ARM_BASE) + 32'(bin_q) * 32'(ARM_STEP);
  assign arm_a   = (arm_sum > 32'(ANG_MAX)) ? ANG_MAX : arm_sum[ANG_W-1:0];

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    side_d   = side_q;
    bin_d    = bin_q;
    fault_d  = 1'b0;
    tgt_we   = '0;
    tgt_val  = '0;

    case (state_q)
      S_IDLE: if (start) begin
        if ((ir_side == LEFT || ir_side == RIGHT) && int'(bin) < N_CH - 2) begin
          state_d = S_BASE;
          side_d  = ir_side;
          bin_d   = bin;
        end else begin
          fault_d = 1'b1;
        end
      end
      S_BASE: if (abort) state_d = S_HOME; else if (step_done) state_d = S_ARM;
      S_ARM:  if (abort) state_d = S_HOME; else if (step_done) state_d = S_GRIP;
      S_GRIP: if (abort || step_done) state_d = S_HOME;
      S_HOME: if (step_done) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) settle_d = '0;
    else if (frame_wrap)    settle_d = all_arrived ? settle_q + SW'(1) : '0;

    // targets are loaded on the same edge the new state is entered
    if (state_d != state_q) begin
      for (int i = 0; i < N_CH; i++) begin
        case (state_d)
          S_BASE: if (i == 0) begin
            tgt_we[i]  = 1'b1;
            tgt_val[i] = (side_d == RIGHT) ? BASE_R : BASE_L;
          end
          S_ARM: if (i == 1) begin
            tgt_we[i]  = 1'b1;
            tgt_val[i] = (side_q == LEFT) ? arm_a : ANG_MAX - arm_a;
          end
          S_GRIP: if (i >= 2 && (i - 2) == int'(bin_q)) begin
            tgt_we[i]  = 1'b1;
            tgt_val[i] = GRIP_CLOSE;
          end
          S_HOME: begin
            tgt_we[i]  = 1'b1;
            tgt_val[i] = (i < 2) ? HOME_ANG : GRIP_OPEN;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      frame_cnt_q <= '0;
      settle_q    <= '0;
      side_q      <= '0;
      bin_q       <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      settle_q    <= settle_d;
      side_q      <= side_d;
      bin_q       <= bin_d;
      fault_q     <= fault_d;
    end
  end

  assign busy  = (state_q == S_BASE) || (state_q == S_ARM) ||
                 (state_q == S_GRIP) || (state_q == S_HOME);
  assign done  = (state_q == S_DONE);
  assign fault = fault_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    servo_ramp_ch #(
      .FCW         (FCW),
      .MIN_CYC     (MIN_CYC),
      .CYC_PER_DEG (CYC_PER_DEG),
      .STEP_DEG    (STEP_DEG),
      .HOME        ((g < 2) ? HOME_ANG : GRIP_OPEN)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .frame_cnt  (frame_cnt_q),
      .frame_wrap (frame_wrap),
      .tgt_we     (tgt_we[g]),
      .tgt_in     (tgt_val[g]),
      .arrived    (arrived[g]),
      .pwm        (pwm_out[g])
    );
  end

endmodule

// File: tb/tb_servo_seq_ctrl.sv
// Directed bench for servo_seq_ctrl on a short 250-cycle frame: pulse width = 20 + angle.
module tb_servo_seq_ctrl;

  localparam int N  = 5;
  localparam int FC = 250;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [1:0]   ir_side = 2'b00;
  logic [1:0]   bin = 2'b00;
  logic         busy, done, fault;
  logic [N-1:0] pwm_out;

  int n_chk = 0;
  int n_fail = 0;
  int w[N];
  int nb, nd, nf;

  always #5 clk = ~clk;

  servo_seq_ctrl #(
    .CLK_HZ(2_000_000), .PWM_HZ(8000), .N_CH(N), .MIN_US(10), .MAX_US(100),
    .STEP_DEG(5), .SETTLE_FRAMES(2), .ARM_BASE(90), .ARM_STEP(45)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .ir_side(ir_side),
    .bin(bin), .busy(busy), .done(done), .fault(fault), .pwm_out(pwm_out)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input int e0, input int e1, input int e2,
                       input int e3, input int e4);
    chk({tag, ".ch0"}, w[0], e0);
    chk({tag, ".ch1"}, w[1], e1);
    chk({tag, ".ch2"}, w[2], e2);
    chk({tag, ".ch3"}, w[3], e3);
    chk({tag, ".ch4"}, w[4], e4);
  endtask

  // Sample one full PWM frame; request pulses are dropped after the first edge.
  task automatic frame();
    foreach (w[i]) w[i] = 0;
    nb = 0; nd = 0; nf = 0;
    repeat (FC) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      for (int i = 0; i < N; i++) w[i] += int'(pwm_out[i]);
      nb += int'(busy);
      nd += int'(done);
      nf += int'(fault);
    end
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst.pwm", int'(pwm_out), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.fault", int'(fault), 0);
    reset = 1'b1;

    // idle frames at home
    frame();
    chk_w("idle", 110, 110, 65, 65, 65);
    chk("idle.busy", nb, 0); chk("idle.done", nd, 0); chk("idle.fault", nf, 0);
    frame();
    chk_w("idle2", 110, 110, 65, 65, 65);

    // left, bin 0
    ir_side = 2'b01; bin = 2'd0; start = 1'b1;
    for (int k = 0; k <= 53; k++) begin
      frame();
      case (k)
        0:  begin chk_w("l0.f0", 110, 110, 65, 65, 65); chk("l0.busy0", nb, 250); end
        1:  chk_w("l0.f1", 105, 110, 65, 65, 65);
        9:  chk_w("l0.f9", 65, 110, 65, 65, 65);
        13: chk_w("l0.f13", 65, 110, 65, 65, 65);
        14: chk_w("l0.f14", 65, 110, 70, 65, 65);
        31: chk_w("l0.f31", 65, 110, 155, 65, 65);
        33: chk_w("l0.f33", 65, 110, 155, 65, 65);
        34: chk_w("l0.f34", 70, 110, 150, 65, 65);
        42: chk_w("l0.f42", 110, 110, 110, 65, 65);
        51: begin chk_w("l0.f51", 110, 110, 65, 65, 65); chk("l0.done51", nd, 0); end
        52: begin chk("l0.done", nd, 1); chk("l0.busy52", nb, 249); end
        53: begin chk("l0.busy53", nb, 0); chk("l0.done53", nd, 0); end
        default: ;
      endcase
    end

    // rejected starts
    ir_side = 2'b00; bin = 2'd0; start = 1'b1;
    frame();
    chk("bad_side.fault", nf, 1); chk("bad_side.busy", nb, 0);
    chk_w("bad_side", 110, 110, 65, 65, 65);
    ir_side = 2'b01; bin = 2'd3; start = 1'b1;
    frame();
    chk("bad_bin.fault", nf, 1); chk("bad_bin.busy", nb, 0);
    chk_w("bad_bin", 110, 110, 65, 65, 65);

    // right, bin 2, with abort in the same idle cycle (start wins)
    ir_side = 2'b10; bin = 2'd2; start = 1'b1; abort = 1'b1;
    for (int k = 0; k <= 71; k++) begin
      frame();
      case (k)
        0:  begin chk_w("r2.f0", 110, 110, 65, 65, 65); chk("r2.busy0", nb, 250); end
        9:  chk_w("r2.f9", 155, 110, 65, 65, 65);
        11: chk_w("r2.f11", 155, 110, 65, 65, 65);
        12: chk_w("r2.f12", 155, 105, 65, 65, 65);
        29: chk_w("r2.f29", 155, 20, 65, 65, 65);
        31: chk_w("r2.f31", 155, 20, 65, 65, 65);
        49: chk_w("r2.f49", 155, 20, 65, 65, 155);
        51: chk_w("r2.f51", 155, 20, 65, 65, 155);
        60: chk_w("r2.f60", 110, 65, 65, 65, 110);
        69: chk_w("r2.f69", 110, 110, 65, 65, 65);
        70: begin chk("r2.done", nd, 1); chk("r2.busy70", nb, 249); end
        71: chk("r2.busy71", nb, 0);
        default: ;
      endcase
    end

    // left, bin 1, abort mid-ARM with arm at 120 deg
    ir_side = 2'b01; bin = 2'd1; start = 1'b1;
    for (int k = 0; k <= 28; k++) begin
      frame();
      case (k)
        12: chk_w("ab.f12", 65, 115, 65, 65, 65);
        16: begin chk_w("ab.f16", 65, 135, 65, 65, 65); abort = 1'b1; end
        17: chk_w("ab.f17", 65, 140, 65, 65, 65);
        18: chk_w("ab.f18", 70, 135, 65, 65, 65);
        23: chk_w("ab.f23", 95, 110, 65, 65, 65);
        26: chk_w("ab.f26", 110, 110, 65, 65, 65);
        27: begin chk("ab.done", nd, 1); chk("ab.busy27", nb, 249); end
        28: chk("ab.busy28", nb, 0);
        default: ;
      endcase
    end

    // reset mid-GRIP snaps every channel home
    ir_side = 2'b01; bin = 2'd0; start = 1'b1;
    for (int k = 0; k <= 19; k++) begin
      frame();
      if (k == 19) chk_w("rg.f19", 65, 110, 95, 65, 65);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rg.rst_pwm", int'(pwm_out), 0);
    chk("rg.rst_busy", int'(busy), 0);
    reset = 1'b1;
    frame();
    chk_w("rg.post", 110, 110, 65, 65, 65);
    chk("rg.post_busy", nb, 0);
    start = 1'b1;
    frame();
    chk("rg.restart_busy", nb, 250);
    frame();
    chk_w("rg.restart_f1", 105, 110, 65, 65, 65);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
